faddsub_pipe: RTL and testbench

FADDSUB_PIPE -- requirements
Module: faddsub_pipe

---
 rtl/faddsub_pipe.sv | 351 +++++++++++++++++++++++++++++++++++
 tb/tb_faddsub_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/faddsub_pipe.sv
// faddsub_pipe -- 4-stage pipelined floating-point adder/subtractor.
//
// Purpose:
//   Computes y = x1 + x2 (op=0) or y = x1 - x2 (op=1) on IEEE-754-style words
//   of 1 sign + EW exponent + MW mantissa bits. Subnormal inputs are flushed
//   to signed zero, and results that fall below the normal range are flushed
//   to signed zero with udf=1. Pipeline stages:
//     1. classify / magnitude compare / swap
//     2. align the smaller operand (guard, round, sticky)
//     3. add or subtract, then normalise
//     4. round, range-check and pack (output register)
//   The whole pipe advances together when the output is free or is being
//   consumed (adv = out_ready | ~out_valid). in_ready equals adv.
//
// Configuration macro:
//   FADDSUB_RNE_EN  defined   -> round-to-nearest-even
//                   undefined -> truncation toward zero (same latency)
//
// Ports:
//   clk        clock, rising edge
//   rstn       asynchronous active-low reset
//   in_valid   x1/x2/op/in_tag carry an operation
//   in_ready   operation presented this cycle is accepted
//   x1, x2     operands {sign, exponent, mantissa}
//   op         0 = add, 1 = subtract
//   in_tag     opaque sideband tag
//   out_valid  y/flags/out_tag are valid
//   out_ready  consumer takes the result this cycle
//   y          result word
//   ovf        overflow to infinity
//   udf        underflow flushed to zero
//   nv         invalid operation (inf - inf, signalling NaN input)
//   out_tag    tag of the operation that produced y
module faddsub_pipe #(
  parameter int EW   = 8,
  parameter int MW   = 23,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [EW+MW:0]  x1,
  input  logic [EW+MW:0]  x2,
  input  logic            op,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [EW+MW:0]  y,
  output logic            ovf,
  output logic            udf,
  output logic            nv,
  output logic [TAGW-1:0] out_tag
);

  localparam int W  = 1 + EW + MW;
  // Aligned mantissa: hidden bit, MW fraction bits, guard, round.
  localparam int XW = MW + 3;
  // Adder width: carry bit, XW aligned bits, sticky as the LSB.
  localparam int SW = MW + 5;
  localparam logic [W-1:0]  QNAN    = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
  localparam logic [EW+1:0] EXP_TOP = (EW+2)'((1 << EW) - 1);

  logic adv;

  // ---------------------------------------------------------------------------
  // Stage 1: classify, compare magnitudes, swap
  // ---------------------------------------------------------------------------
  logic          sa, sb, sb_raw;
  logic [EW-1:0] ea, eb;
  logic [MW-1:0] fa, fb, fa_f, fb_f;
  logic          a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic          a_ge;

  assign {sa, ea, fa}     = x1;
  assign {sb_raw, eb, fb} = x2;
  assign sb     = sb_raw ^ op;
  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);
  assign a_snan = a_nan & ~fa[MW-1];
  assign b_snan = b_nan & ~fb[MW-1];
  assign a_inf  = (&ea) & ~(|fa);
  assign b_inf  = (&eb) & ~(|fb);
  assign a_zero = ~(|ea);
  assign b_zero = ~(|eb);
  // Subnormals behave as zero, so their fraction must not win the compare.
  assign fa_f   = a_zero ? '0 : fa;
  assign fb_f   = b_zero ? '0 : fb;
  assign a_ge   = {ea, fa_f} >= {eb, fb_f};

  logic          s1_spec_next, s1_spec_nv_next, s1_sign_next, s1_sub_next;
  logic [W-1:0]  s1_spec_y_next;
  logic [EW-1:0] s1_exp_next, s1_diff_next;
  logic [MW:0]   s1_man_big_next, s1_man_small_next;

  always_comb begin
    s1_spec_next    = a_nan | b_nan | a_inf | b_inf;
    s1_spec_y_next  = QNAN;
    s1_spec_nv_next = 1'b0;
    if (a_nan | b_nan) begin
      s1_spec_nv_next = a_snan | b_snan;
    end else if (a_inf & b_inf & (sa ^ sb)) begin
      s1_spec_nv_next = 1'b1;
    end else if (a_inf) begin
      s1_spec_y_next = {sa, {EW{1'b1}}, {MW{1'b0}}};
    end else if (b_inf) begin
      s1_spec_y_next = {sb, {EW{1'b1}}, {MW{1'b0}}};
    end

    s1_sub_next = sa ^ sb;
    if (a_ge) begin
      s1_sign_next      = sa;
      s1_exp_next       = ea;
      s1_diff_next      = ea - eb;
      s1_man_big_next   = {~a_zero, fa_f};
      s1_man_small_next = {~b_zero, fb_f};
    end else begin
      s1_sign_next      = sb;
      s1_exp_next       = eb;
      s1_diff_next      = eb - ea;
      s1_man_big_next   = {~b_zero, fb_f};
      s1_man_small_next = {~a_zero, fa_f};
    end
  end

  logic            s1_valid_reg, s1_spec_reg, s1_spec_nv_reg, s1_sign_reg, s1_sub_reg;
  logic [TAGW-1:0] s1_tag_reg;
  logic [W-1:0]    s1_spec_y_reg;
  logic [EW-1:0]   s1_exp_reg, s1_diff_reg;
  logic [MW:0]     s1_man_big_reg, s1_man_small_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_reg     <= 1'b0;
      s1_tag_reg       <= '0;
      s1_spec_reg      <= 1'b0;
      s1_spec_nv_reg   <= 1'b0;
      s1_spec_y_reg    <= '0;
      s1_sign_reg      <= 1'b0;
      s1_sub_reg       <= 1'b0;
      s1_exp_reg       <= '0;
      s1_diff_reg      <= '0;
      s1_man_big_reg   <= '0;
      s1_man_small_reg <= '0;
    end else if (adv) begin
      s1_valid_reg     <= in_valid;
      s1_tag_reg       <= in_tag;
      s1_spec_reg      <= s1_spec_next;
      s1_spec_nv_reg   <= s1_spec_nv_next;
      s1_spec_y_reg    <= s1_spec_y_next;
      s1_sign_reg      <= s1_sign_next;
      s1_sub_reg       <= s1_sub_next;
      s1_exp_reg       <= s1_exp_next;
      s1_diff_reg      <= s1_diff_next;
      s1_man_big_reg   <= s1_man_big_next;
      s1_man_small_reg <= s1_man_small_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: align the smaller operand, collecting sticky
  // ---------------------------------------------------------------------------
  logic [XW-1:0] small_ext, shifted, lost;
  logic [31:0]   diff32;
  logic          sticky;

  assign small_ext = {s1_man_small_reg, 2'b00};
  assign diff32    = 32'(s1_diff_reg);
  // A shift of XW or more yields zero, leaving only sticky.
  assign shifted   = small_ext >> diff32;

  // Bit gi leaves the aligned window when the shift distance exceeds gi.
  for (genvar gi = 0; gi < XW; gi++) begin : g_sticky
    assign lost[gi] = small_ext[gi] & (diff32 > 32'(gi));
  end
  assign sticky = |lost;

  logic            s2_valid_reg, s2_spec_reg, s2_spec_nv_reg, s2_sign_reg, s2_sub_reg, s2_sticky_reg;
  logic [TAGW-1:0] s2_tag_reg;
  logic [W-1:0]    s2_spec_y_reg;
  logic [EW-1:0]   s2_exp_reg;
  logic [XW-1:0]   s2_big_ext_reg, s2_small_ext_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid_reg     <= 1'b0;
      s2_tag_reg       <= '0;
      s2_spec_reg      <= 1'b0;
      s2_spec_nv_reg   <= 1'b0;
      s2_spec_y_reg    <= '0;
      s2_sign_reg      <= 1'b0;
      s2_sub_reg       <= 1'b0;
      s2_exp_reg       <= '0;
      s2_big_ext_reg   <= '0;
      s2_small_ext_reg <= '0;
      s2_sticky_reg    <= 1'b0;
    end else if (adv) begin
      s2_valid_reg     <= s1_valid_reg;
      s2_tag_reg       <= s1_tag_reg;
      s2_spec_reg      <= s1_spec_reg;
      s2_spec_nv_reg   <= s1_spec_nv_reg;
      s2_spec_y_reg    <= s1_spec_y_reg;
      s2_sign_reg      <= s1_sign_reg;
      s2_sub_reg       <= s1_sub_reg;
      s2_exp_reg       <= s1_exp_reg;
      s2_big_ext_reg   <= {s1_man_big_reg, 2'b00};
      s2_small_ext_reg <= shifted;
      s2_sticky_reg    <= sticky;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: add/subtract magnitudes and normalise
  // ---------------------------------------------------------------------------
  logic [SW-1:0] a_op, b_op, sum;
  logic [SW-2:0] norm;
  logic [EW+1:0] exp_n;     // two's complement, so underflow shows as negative
  logic          s3_sign_next;
  int            lz;

  always_comb begin
    a_op = {1'b0, s2_big_ext_reg, 1'b0};
    b_op = {1'b0, s2_small_ext_reg, s2_sticky_reg};
    // The swap guarantees |a_op| >= |b_op|, so the difference never goes negative.
    sum  = s2_sub_reg ? (a_op - b_op) : (a_op + b_op);

    lz = 0;
    for (int i = 0; i < SW - 1; i++) begin
      if (sum[i]) lz = SW - 2 - i;
    end

    if (sum[SW-1]) begin
      norm    = sum[SW-1:1];
      norm[0] = sum[1] | sum[0];
      exp_n   = {2'b00, s2_exp_reg} + (EW+2)'(1);
    end else begin
      norm  = sum[SW-2:0] << lz;
      exp_n = {2'b00, s2_exp_reg} - (EW+2)'(lz);
    end

    // Exact cancellation of opposite-signed operands yields +0.
    s3_sign_next = (s2_sub_reg && (sum == '0)) ? 1'b0 : s2_sign_reg;
  end

  logic            s3_valid_reg, s3_spec_reg, s3_spec_nv_reg, s3_sign_reg;
  logic            s3_hid_reg, s3_g_reg, s3_r_reg, s3_s_reg;
  logic [TAGW-1:0] s3_tag_reg;
  logic [W-1:0]    s3_spec_y_reg;
  logic [EW+1:0]   s3_exp_reg;
  logic [MW-1:0]   s3_frac_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s3_valid_reg   <= 1'b0;
      s3_tag_reg     <= '0;
      s3_spec_reg    <= 1'b0;
      s3_spec_nv_reg <= 1'b0;
      s3_spec_y_reg  <= '0;
      s3_sign_reg    <= 1'b0;
      s3_exp_reg     <= '0;
      s3_hid_reg     <= 1'b0;
      s3_frac_reg    <= '0;
      s3_g_reg       <= 1'b0;
      s3_r_reg       <= 1'b0;
      s3_s_reg       <= 1'b0;
    end else if (adv) begin
      s3_valid_reg   <= s2_valid_reg;
      s3_tag_reg     <= s2_tag_reg;
      s3_spec_reg    <= s2_spec_reg;
      s3_spec_nv_reg <= s2_spec_nv_reg;
      s3_spec_y_reg  <= s2_spec_y_reg;
      s3_sign_reg    <= s3_sign_next;
      s3_exp_reg     <= exp_n;
      s3_hid_reg     <= norm[SW-2];
      s3_frac_reg    <= norm[SW-3:3];
      s3_g_reg       <= norm[2];
      s3_r_reg       <= norm[1];
      s3_s_reg       <= norm[0];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 4: round, range-check, pack
  // ---------------------------------------------------------------------------
  logic          round_up, is_zero;
  logic [MW:0]   mant_r;
  logic [EW+1:0] exp_r;
  logic [W-1:0]  y_next;
  logic          ovf_next, udf_next, nv_next;

  always_comb begin
`ifdef FADDSUB_RNE_EN
    round_up = s3_g_reg & (s3_r_reg | s3_s_reg | s3_frac_reg[0]);
`else
    round_up = 1'b0;
`endif
    // A carry out of the fraction leaves it all-zero; bump the exponent.
    mant_r  = {1'b0, s3_frac_reg} + (MW+1)'(round_up);
    exp_r   = s3_exp_reg + (EW+2)'(mant_r[MW]);
    is_zero = ~(s3_hid_reg | (|s3_frac_reg) | s3_g_reg | s3_r_reg | s3_s_reg);

    y_next   = {s3_sign_reg, exp_r[EW-1:0], mant_r[MW-1:0]};
    ovf_next = 1'b0;
    udf_next = 1'b0;
    nv_next  = 1'b0;
    if (s3_spec_reg) begin
      y_next  = s3_spec_y_reg;
      nv_next = s3_spec_nv_reg;
    end else if (is_zero) begin
      y_next = {s3_sign_reg, {(W-1){1'b0}}};
    end else if (exp_r[EW+1] || (exp_r == '0)) begin
      y_next   = {s3_sign_reg, {(W-1){1'b0}}};
      udf_next = 1'b1;
    end else if (exp_r >= EXP_TOP) begin
      y_next   = {s3_sign_reg, {EW{1'b1}}, {MW{1'b0}}};
      ovf_next = 1'b1;
    end
  end

  logic            out_valid_reg, ovf_reg, udf_reg, nv_reg;
  logic [W-1:0]    y_reg;
  logic [TAGW-1:0] out_tag_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_reg <= 1'b0;
      y_reg         <= '0;
      ovf_reg       <= 1'b0;
      udf_reg       <= 1'b0;
      nv_reg        <= 1'b0;
      out_tag_reg   <= '0;
    end else if (adv) begin
      out_valid_reg <= s3_valid_reg;
      y_reg         <= y_next;
      ovf_reg       <= ovf_next;
      udf_reg       <= udf_next;
      nv_reg        <= nv_next;
      out_tag_reg   <= s3_tag_reg;
    end
  end

  assign adv       = out_ready | ~out_valid_reg;
  assign in_ready  = adv;
  assign out_valid = out_valid_reg;
  assign y         = y_reg;
  assign ovf       = ovf_reg;
  assign udf       = udf_reg;
  assign nv        = nv_reg;
  assign out_tag   = out_tag_reg;

endmodule

// File: tb/tb_faddsub_pipe.sv
// tb_faddsub_pipe -- directed self-checking bench for faddsub_pipe
// (default parameters: EW=8, MW=23, TAGW=4).
// Covers reset state, single operations with latency, special values,
// rounding (mode follows FADDSUB_RNE_EN), a stalled tagged stream, and
// reset with operations in flight.
module tb_faddsub_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1, x2;
  logic        op;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        ovf, udf, nv;
  logic [3:0]  out_tag;

  faddsub_pipe dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .op        (op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .ovf       (ovf),
    .udf       (udf),
    .nv        (nv),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

`ifdef FADDSUB_RNE_EN
  localparam logic [31:0] EXP_TIE   = 32'h3F800001;
  localparam logic [31:0] EXP_CARRY = 32'h40000000;
`else
  localparam logic [31:0] EXP_TIE   = 32'h3F800000;
  localparam logic [31:0] EXP_CARRY = 32'h3FFFFFFF;
`endif

  // flags packed as {ovf, udf, nv}
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        o;
    logic [31:0] ey;
    logic [2:0]  ef;
  } vec_t;

  localparam int NV = 16;
  vec_t vt [0:NV-1];
  vec_t st [0:7];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one operation, wait for its result; lat counts rising edges
  // from acceptance until out_valid is seen.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic o,
                       input logic [3:0] t, output logic [31:0] ry, output logic [2:0] rf,
                       output logic [3:0] rt, output int lat);
    @(negedge clk);
    x1 = a; x2 = b; op = o; in_tag = t; in_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      in_valid = 1'b0;
    end while (!out_valid && lat < 20);
    ry = y;
    rf = {ovf, udf, nv};
    rt = out_tag;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] ry;
  logic [2:0]  rf;
  logic [3:0]  rt;
  int          lat;
  logic [31:0] got_y [0:7];
  logic [3:0]  got_t [0:7];
  int          n_got;
  int          sent;
  logic        acc;

  initial begin
    vt[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000};
    vt[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000};
    vt[2]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100};
    vt[3]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b001};
    vt[4]  = '{32'h3F800000, 32'h33C00000, 1'b0, EXP_TIE,      3'b000};
    vt[5]  = '{32'h3FFFFFFF, 32'h33800000, 1'b0, EXP_CARRY,    3'b000};
    vt[6]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000};
    vt[7]  = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b001};
    vt[8]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000};
    vt[9]  = '{32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 3'b010};
    vt[10] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000};
    vt[11] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000};
    vt[12] = '{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 3'b000};
    vt[13] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000};
    vt[14] = '{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 3'b000};
    vt[15] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b001};

    st[0] = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000};
    st[1] = '{32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 3'b000};
    st[2] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000};
    st[3] = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000};
    st[4] = '{32'h40800000, 32'h3F800000, 1'b1, 32'h40400000, 3'b000};
    st[5] = '{32'h3FC00000, 32'h3F000000, 1'b0, 32'h40000000, 3'b000};
    st[6] = '{32'hBF800000, 32'hBF800000, 1'b0, 32'hC0000000, 3'b000};
    st[7] = '{32'h3F000000, 32'h3E800000, 1'b1, 32'h3E800000, 3'b000};

    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x1 = '0; x2 = '0; op = 1'b0; in_tag = '0;

    // Reset state
    #3;
    check_eq("rst_out_valid", 64'(out_valid), 64'(0));
    check_eq("rst_y", 64'(y), 64'(0));
    check_eq("rst_flags", 64'({ovf, udf, nv}), 64'(0));
    check_eq("rst_out_tag", 64'(out_tag), 64'(0));
    check_eq("rst_in_ready", 64'(in_ready), 64'(1));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    check_eq("post_rst_in_ready", 64'(in_ready), 64'(1));

    // Directed single operations
    for (int i = 0; i < NV; i++) begin
      do_op(vt[i].a, vt[i].b, vt[i].o, 4'(i), ry, rf, rt, lat);
      $display("vec %0d: %h %s %h -> y=%h flags=%b tag=%0d lat=%0d",
               i, vt[i].a, vt[i].o ? "-" : "+", vt[i].b, ry, rf, rt, lat);
      check_eq($sformatf("vec%0d_y", i), 64'(ry), 64'(vt[i].ey));
      check_eq($sformatf("vec%0d_flags", i), 64'(rf), 64'(vt[i].ef));
      check_eq($sformatf("vec%0d_tag", i), 64'(rt), 64'(i));
      check_eq($sformatf("vec%0d_latency", i), 64'(lat), 64'(4));
    end

    // Back-to-back tagged stream with a 3-cycle consumer stall
    @(negedge clk);
    n_got = 0;
    sent  = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = !(cyc >= 5 && cyc < 8);
      if (sent < 8) begin
        x1 = st[sent].a; x2 = st[sent].b; op = st[sent].o;
        in_tag = 4'(sent + 1); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        $display("stream out %0d: y=%h tag=%0d", n_got, y, out_tag);
        if (n_got < 8) begin
          got_y[n_got] = y;
          got_t[n_got] = out_tag;
        end
        n_got++;
      end
      @(posedge clk);
      if (acc) sent++;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq("stream_count", 64'(n_got), 64'(8));
    for (int i = 0; i < 8; i++) begin
      if (i < n_got) begin
        check_eq($sformatf("stream%0d_y", i), 64'(got_y[i]), 64'(st[i].ey));
        check_eq($sformatf("stream%0d_tag", i), 64'(got_t[i]), 64'(i + 1));
      end else begin
        check_eq($sformatf("stream%0d_missing", i), 64'(0), 64'(1));
      end
    end

    // Reset with three operations in flight (consumer stalled)
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      x1 = st[k].a; x2 = st[k].b; op = st[k].o; in_tag = 4'(10 + k); in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("pre_rst_out_valid", 64'(out_valid), 64'(1));
    #2 rstn = 1'b0;
    #1;
    $display("reset pulse: out_valid=%0d y=%h tag=%0d", out_valid, y, out_tag);
    check_eq("midrst_out_valid", 64'(out_valid), 64'(0));
    check_eq("midrst_y", 64'(y), 64'(0));
    check_eq("midrst_out_tag", 64'(out_tag), 64'(0));
    check_eq("midrst_flags", 64'({ovf, udf, nv}), 64'(0));
    check_eq("midrst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rstn = 1'b1;
    out_ready = 1'b1;
    x1 = 32'h3F800000; x2 = 32'h40000000; op = 1'b0; in_tag = 4'd13; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_got = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      if (out_valid) begin
        $display("post-reset out: y=%h tag=%0d", y, out_tag);
        if (n_got == 0) begin
          got_y[0] = y;
          got_t[0] = out_tag;
        end
        n_got++;
      end
      @(negedge clk);
    end
    check_eq("postrst_count", 64'(n_got), 64'(1));
    if (n_got > 0) begin
      check_eq("postrst_tag", 64'(got_t[0]), 64'(13));
      check_eq("postrst_y", 64'(got_y[0]), 64'(32'h40400000));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
